// File: rtl/cu_pkg.sv
// Shared types and constants for the compute-unit instruction issuer.
// Provides the issuer state enum, compute-unit opcode values and the NOP word.
package cu_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h9;
    localparam logic [3:0] OP_ADD  = 4'hA;
    localparam logic [3:0] OP_SUB  = 4'hB;
    localparam logic [3:0] OP_AND  = 4'hC;
    localparam logic [3:0] OP_OR   = 4'hD;
    localparam logic [3:0] OP_NOT  = 4'hE;
    localparam logic [3:0] OP_XOR  = 4'hF;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/cu_instr_issuer_if.sv
// Host/compute-unit side bundle of the instruction issuer.
// master: host + compute unit (drives load/start/clear and result_in).
// slave : issuer (drives load_ready, instr, cu_ena, result stream, status).
interface cu_instr_issuer_if
    import cu_pkg::*;
#(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic               clear;
    logic               load_valid;
    logic [BYTE_W-1:0]  load_byte;
    logic               load_ready;
    logic               start;
    logic [INSTR_W-1:0] instr;
    logic               cu_ena;
    logic [BYTE_W-1:0]  result_in;
    logic               res_valid;
    logic [BYTE_W-1:0]  res_data;
    logic [IDX_W-1:0]   res_idx;
    logic [BYTE_W-1:0]  checksum;
    logic               busy;
    logic               done;

    modport master (
        output clear, load_valid, load_byte, start, result_in,
        input  load_ready, instr, cu_ena, res_valid, res_data, res_idx,
               checksum, busy, done
    );

    modport slave (
        input  clear, load_valid, load_byte, start, result_in,
        output load_ready, instr, cu_ena, res_valid, res_data, res_idx,
               checksum, busy, done
    );

endinterface

// File: rtl/cu_prog_buf.sv
// Program buffer: DEPTH x 16-bit register file, one write port,
// one asynchronous read port. Data is not reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module cu_prog_buf
    import cu_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cu_instr_issuer.sv
// Instruction issuer: loads a byte-wise program, then issues each 16-bit
// instruction to the compute unit with a one-cycle enable, captures the result
// RESULT_LAT cycles later, streams it out with its index and keeps an XOR
// checksum.
// Ports: clk, rst (async, active-high), bus (cu_instr_issuer_if.slave).
module cu_instr_issuer
    import cu_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned RESULT_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    cu_instr_issuer_if.slave   bus
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;
    localparam int unsigned LW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(RESULT_LAT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic               phase_q, phase_d;
    logic [BYTE_W-1:0]  hi_q, hi_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [LW-1:0]      lat_q, lat_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               cu_ena_q, cu_ena_d;
    logic               res_valid_q, res_valid_d;
    logic [BYTE_W-1:0]  res_data_q, res_data_d;
    logic [IW-1:0]      res_idx_q, res_idx_d;
    logic [BYTE_W-1:0]  checksum_q, checksum_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               load_ready_q, load_ready_d;

    logic               wr_en;
    logic [INSTR_W-1:0] rd_data;

    cu_prog_buf #(.DEPTH(DEPTH)) u_prog_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (count_q[IW-1:0]),
        .wdata ({hi_q, bus.load_byte}),
        .raddr (idx_d),
        .rdata (rd_data)
    );

    // Next-state, buffer loading, sequencing and result capture.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        checksum_d  = checksum_q;
        wr_en       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.clear) begin
                    count_d = '0;
                    phase_d = 1'b0;
                end else if (bus.start) begin
                    // Any pending high byte is dropped.
                    phase_d    = 1'b0;
                    idx_d      = '0;
                    checksum_d = '0;
                    state_d    = (count_q == '0) ? ST_DONE : ST_ISSUE;
                end else if (bus.load_valid && load_ready_q) begin
                    if (!phase_q) begin
                        hi_d    = bus.load_byte;
                        phase_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        count_d = count_q + CW'(1);
                        phase_d = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                lat_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    res_valid_d = 1'b1;
                    res_data_d  = bus.result_in;
                    res_idx_d   = idx_q;
                    checksum_d  = checksum_q ^ bus.result_in;
                    if (CW'(idx_q) + CW'(1) == count_q) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_ISSUE;
                    end
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the upcoming state.
    always_comb begin
        instr_d      = instr_q;
        cu_ena_d     = 1'b0;
        done_d       = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        load_ready_d = (state_d == ST_IDLE) && (count_d != COUNT_FULL);
        if (state_d == ST_ISSUE) begin
            instr_d  = rd_data;
            cu_ena_d = 1'b1;
        end else if (state_d == ST_DONE) begin
            instr_d = NOP_INSTR;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            idx_q        <= '0;
            lat_q        <= '0;
            instr_q      <= NOP_INSTR;
            cu_ena_q     <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_idx_q    <= '0;
            checksum_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            idx_q        <= idx_d;
            lat_q        <= lat_d;
            instr_q      <= instr_d;
            cu_ena_q     <= cu_ena_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_idx_q    <= res_idx_d;
            checksum_q   <= checksum_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign bus.instr      = instr_q;
    assign bus.cu_ena     = cu_ena_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_idx    = res_idx_q;
    assign bus.checksum   = checksum_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.load_ready = load_ready_q;

endmodule
